// File: rtl/fir_out_decimator.sv
// fir_out_decimator: averages groups of 2^dec_log2 filter samples, rounds
// half-up, saturates to 8 bits and buffers the results in a small
// first-word-fall-through FIFO with a sticky overflow flag.
module fir_out_decimator #(
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [15:0]                 y_in,
  input  logic                        y_valid,
  input  logic [1:0]                  dec_log2,
  output logic [7:0]                  out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        ovf,
  input  logic                        ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  // group accumulation state
  logic [2:0]  phase;
  logic [1:0]  dec_lat;
  logic [19:0] acc;

  // combinational datapath
  logic [1:0]  cur_log2;
  logic [2:0]  last_phase;
  logic        group_end;
  logic [19:0] sum;
  int          k;
  logic [31:0] rounded;
  logic [7:0]  sat;

  // result pipeline stage
  logic        res_vld;
  logic [7:0]  res_data;

  // FIFO storage and control
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          pop;
  logic          full;
  logic          do_push;
  logic          drop;

  // Form the group sum, the effective shift and the rounded, saturated result.
  // At phase 0 the incoming dec_log2 applies, since that is when it is latched.
  always_comb begin
    cur_log2 = (phase == 3'd0) ? dec_log2 : dec_lat;
    case (cur_log2)
      2'd0:    last_phase = 3'd0;
      2'd1:    last_phase = 3'd1;
      2'd2:    last_phase = 3'd3;
      default: last_phase = 3'd7;
    endcase
    group_end = (phase == last_phase);
    sum       = ((phase == 3'd0) ? 20'd0 : acc) + {4'd0, y_in};
    k         = int'(cur_log2) + SHIFT;
    if (k == 0) begin
      rounded = {12'd0, sum};
    end else begin
      rounded = ({12'd0, sum} + (32'd1 << (k - 1))) >> k;
    end
    sat = (rounded > 32'd255) ? 8'hFF : rounded[7:0];
  end

  // Count accepted samples within a group and keep the running sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= 3'd0;
      dec_lat <= 2'd0;
      acc     <= 20'd0;
    end else if (y_valid) begin
      phase <= group_end ? 3'd0 : phase + 3'd1;
      if (phase == 3'd0) begin
        dec_lat <= dec_log2;
      end
      acc <= sum;
    end
  end

  // Register the finished group result one cycle before it enters the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_vld  <= 1'b0;
      res_data <= 8'd0;
    end else begin
      res_vld <= y_valid & group_end;
      if (y_valid & group_end) begin
        res_data <= sat;
      end
    end
  end

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  always_comb begin
    pop     = out_valid & out_ready;
    full    = (cnt == CNT_FULL);
    do_push = res_vld & (~full | pop);
    drop    = res_vld & full & ~pop;
  end

  // Storage array needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= res_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (do_push && !pop) begin
        cnt <= cnt + CNT_ONE;
      end else if (pop && !do_push) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear leaves it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  assign out_valid = (cnt != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'd0;
  assign fifo_cnt  = cnt;

endmodule
